// File: rtl/elevator_scheduler.sv
// SCAN request scheduler for the 4-floor elevator car FSM: latches floor calls,
// steers the car through target/stop and times the door dwell at each served floor.
module elevator_scheduler #(
  parameter int unsigned DOOR_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] call_req,
  input  logic       estop,
  input  logic [1:0] floor,
  output logic [1:0] target,
  output logic       stop,
  output logic       door_open,
  output logic       dir_up,
  output logic [3:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_e;

  localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] target_q, target_d;
  logic       dir_up_q, dir_up_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] cnt_q, cnt_d;

  logic [3:0] call_mask;
  logic [2:0] up_hit, dn_hit;
  logic       go_up;

  // Nearest pending floor strictly above `from`; bit 2 flags that one exists.
  function automatic logic [2:0] nearest_up(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--)
      if (req[i] && (i > int'(from))) r = {1'b1, 2'(i)};
    return r;
  endfunction

  // Nearest pending floor strictly below `from`; bit 2 flags that one exists.
  function automatic logic [2:0] nearest_dn(input logic [3:0] req, input logic [1:0] from);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i <= 3; i++)
      if (req[i] && (i < int'(from))) r = {1'b1, 2'(i)};
    return r;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    target_d  = target_q;
    dir_up_d  = dir_up_q;
    cnt_d     = cnt_q;
    go_up     = 1'b1;
    call_mask = call_req;
    if (state_q == DOOR) call_mask[floor] = 1'b0;
    pending_d = pending_q | call_mask;
    up_hit    = nearest_up(pending_q, floor);
    dn_hit    = nearest_dn(pending_q, floor);

    if (!estop) begin
      unique case (state_q)
        IDLE: begin
          if (pending_q[floor]) begin
            state_d          = DOOR;
            pending_d[floor] = 1'b0;
            cnt_d            = DOOR_LOAD;
          end else if (|pending_q) begin
            go_up    = dir_up_q ? (up_hit[2] || !dn_hit[2]) : !dn_hit[2];
            dir_up_d = go_up;
            target_d = go_up ? up_hit[1:0] : dn_hit[1:0];
            state_d  = MOVING;
          end else begin
            target_d = floor;
          end
        end
        MOVING: begin
          if (floor == target_q) begin
            state_d             = DOOR;
            pending_d[target_q] = 1'b0;
            cnt_d               = DOOR_LOAD;
          end else if (dir_up_q) begin
            if (up_hit[2] && (up_hit[1:0] < target_q)) target_d = up_hit[1:0];
          end else begin
            if (dn_hit[2] && (dn_hit[1:0] > target_q)) target_d = dn_hit[1:0];
          end
        end
        DOOR: begin
          // A repeat call for the floor being served keeps the door open longer.
          if (call_req[floor])  cnt_d   = DOOR_LOAD;
          else if (cnt_q == '0) state_d = IDLE;
          else                  cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    if (reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stop      = (state_q != MOVING) | estop;
  assign door_open = (state_q == DOOR);
  assign target    = target_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;
  assign busy      = (state_q != IDLE) | (|pending_q);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a one-floor-per-edge car model
// standing in for the car FSM.
module tb_elevator_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] call_req;
  logic       estop;
  logic [1:0] floor;
  logic [1:0] target;
  logic       stop;
  logic       door_open;
  logic       dir_up;
  logic [3:0] pending;
  logic       busy;

  logic       car_load;
  logic [1:0] car_load_val;
  logic [1:0] car_floor;

  int total = 0;
  int bad   = 0;

  elevator_scheduler #(.DOOR_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .call_req  (call_req),
    .estop     (estop),
    .floor     (floor),
    .target    (target),
    .stop      (stop),
    .door_open (door_open),
    .dir_up    (dir_up),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Car FSM model: steps one floor toward target on each edge while stop is low.
  always @(posedge clock) begin
    if (car_load)                      car_floor <= car_load_val;
    else if (!stop && car_floor < target) car_floor <= car_floor + 2'd1;
    else if (!stop && car_floor > target) car_floor <= car_floor - 2'd1;
  end
  assign floor = car_floor;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] f);
    reset        = 1'b1;
    car_load     = 1'b1;
    car_load_val = f;
    tick();
    reset    = 1'b0;
    car_load = 1'b0;
  endtask

  task automatic wait_door(input string tag, input int max);
    int i;
    i = 0;
    while (!door_open && i < max) begin
      tick();
      i++;
    end
    check(tag, 32'(door_open), 1);
  endtask

  task automatic count_door(output int n);
    n = 0;
    while (door_open && n < 40) begin
      n++;
      tick();
    end
  endtask

  int         n;
  int         k;
  logic [1:0] served [3];
  logic       served_dir [3];
  logic       prev_door;

  initial begin
    reset = 1'b1; call_req = '0; estop = 1'b0; car_load = 1'b0; car_load_val = '0;
    do_reset(2'd0);

    // Reset state
    check("rst_stop", 32'(stop), 1);
    check("rst_door", 32'(door_open), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_target", 32'(target), 0);
    check("rst_dir", 32'(dir_up), 1);
    check("rst_pending", 32'(pending), 0);

    // Basic trip 0 -> 2
    call_req = 4'b0100;
    tick();
    call_req = '0;
    check("basic_pend", 32'(pending), 4'b0100);
    check("basic_stop_idle", 32'(stop), 1);
    tick();
    check("basic_target", 32'(target), 2);
    check("basic_stop_move", 32'(stop), 0);
    tick();
    tick();
    check("basic_floor", 32'(floor), 2);
    check("basic_no_door_yet", 32'(door_open), 0);
    tick();
    check("basic_door", 32'(door_open), 1);
    count_door(n);
    check("basic_dwell", 32'(n), 4);
    check("basic_pend_clr", 32'(pending), 0);
    check("basic_busy", 32'(busy), 0);

    // Intermediate retarget on the way 0 -> 3
    do_reset(2'd0);
    call_req = 4'b1000;
    tick();
    call_req = '0;
    tick();
    check("rt_target3", 32'(target), 3);
    call_req = 4'b0100;
    tick();
    call_req = '0;
    check("rt_floor1", 32'(floor), 1);
    check("rt_target_hold", 32'(target), 3);
    tick();
    check("rt_target2", 32'(target), 2);
    tick();
    check("rt_door2", 32'(door_open), 1);
    check("rt_floor2", 32'(floor), 2);
    count_door(n);
    check("rt_dwell2", 32'(n), 4);
    wait_door("rt_door3_seen", 20);
    check("rt_floor3", 32'(floor), 3);
    check("rt_dir", 32'(dir_up), 1);

    // SCAN ordering from floor 1 going up with calls 0, 2, 3
    do_reset(2'd1);
    call_req = 4'b1101;
    tick();
    call_req = '0;
    check("scan_pend", 32'(pending), 4'b1101);
    k = 0;
    prev_door = 1'b0;
    for (int c = 0; c < 80 && k < 3; c++) begin
      tick();
      if (door_open && !prev_door) begin
        served[k]     = floor;
        served_dir[k] = dir_up;
        k++;
      end
      prev_door = door_open;
    end
    check("scan_count", 32'(k), 3);
    if (k == 3) begin
      check("scan_first", 32'(served[0]), 2);
      check("scan_second", 32'(served[1]), 3);
      check("scan_third", 32'(served[2]), 0);
      check("scan_dir_at3", 32'(served_dir[1]), 1);
      check("scan_dir_at0", 32'(served_dir[2]), 0);
    end

    // Same-floor call in IDLE, then a repeat call during DOOR
    do_reset(2'd1);
    call_req = 4'b0010;
    tick();
    call_req = '0;
    check("same_pend", 32'(pending), 4'b0010);
    check("same_no_door", 32'(door_open), 0);
    tick();
    check("same_door", 32'(door_open), 1);
    check("same_pend_clr", 32'(pending), 0);
    tick();
    call_req = 4'b0010;
    tick();
    call_req = '0;
    check("same_not_latched", 32'(pending), 0);
    count_door(n);
    check("same_extended", 32'(n), 4);
    check("same_floor", 32'(floor), 1);

    // Emergency stop mid-trip 1 -> 3
    do_reset(2'd1);
    call_req = 4'b1000;
    tick();
    call_req = '0;
    tick();
    tick();
    check("es_floor2", 32'(floor), 2);
    estop = 1'b1;
    #1;
    check("es_stop_now", 32'(stop), 1);
    call_req = 4'b0001;
    tick();
    call_req = '0;
    tick();
    tick();
    check("es_floor_hold", 32'(floor), 2);
    check("es_pend", 32'(pending), 4'b1001);
    check("es_target_hold", 32'(target), 3);
    estop = 1'b0;
    #1;
    check("es_release_stop", 32'(stop), 0);
    tick();
    check("es_floor3", 32'(floor), 3);
    tick();
    check("es_door3", 32'(door_open), 1);
    count_door(n);

    // Reset mid-trip (heading down to 0 for the call left pending)
    tick();
    tick();
    check("rm_moving", 32'(stop), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rm_stop", 32'(stop), 1);
    check("rm_door", 32'(door_open), 0);
    check("rm_pend", 32'(pending), 0);
    check("rm_target", 32'(target), 0);
    check("rm_dir", 32'(dir_up), 1);

    // Reset mid-door with a nonzero target and another call pending
    do_reset(2'd0);
    call_req = 4'b0100;
    tick();
    call_req = '0;
    wait_door("rd_door_seen", 20);
    call_req = 4'b1000;
    tick();
    call_req = '0;
    check("rd_target2", 32'(target), 2);
    check("rd_pend", 32'(pending), 4'b1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rd_door", 32'(door_open), 0);
    check("rd_stop", 32'(stop), 1);
    check("rd_pend_clr", 32'(pending), 0);
    check("rd_target", 32'(target), 0);
    check("rd_dir", 32'(dir_up), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
